udma_uart_rx: RTL and testbench

Serial receive engine of the uDMA UART peripheral. It synchronises the asynchronous rx line and detects start bits. It deserialises 5–8 data bits, checks optional even parity and the stop bit(s), then delivers each byte on a valid/ready stream toward the uDMA RX channel. Its outputs also drive the error and polled-data inputs of the UART register interface, and its configuration comes from that interface's UART_SETUP fields.

---
 rtl/udma_uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_udma_uart_rx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_uart_rx.sv
// uDMA UART receive engine: line synchroniser, frame FSM and
// valid/ready byte delivery with parity, overflow and frame errors.
module udma_uart_rx (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        rx_i,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    output logic        busy_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        err_parity_o,
    output logic        err_overflow_o,
    output logic        err_frame_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      state;
    logic        sync1;
    logic        sync2;
    logic        prev;
    logic [15:0] cnt;
    logic [15:0] div_q;
    logic [1:0]  bits_q;
    logic        par_q;
    logic        stop2_q;
    logic        stop_idx;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        par_err;

    logic [15:0] d_eff;
    logic        fall;
    logic        hit;
    logic        last_bit;

    assign d_eff    = (div_q < 16'd3) ? 16'd3 : div_q;
    assign fall     = prev & ~sync2;
    assign hit      = (cnt == d_eff);
    assign last_bit = (idx == {1'b1, bits_q});

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            cnt            <= 16'd0;
            div_q          <= 16'd0;
            bits_q         <= 2'd0;
            par_q          <= 1'b0;
            stop2_q        <= 1'b0;
            stop_idx       <= 1'b0;
            idx            <= 3'd0;
            shreg          <= 8'd0;
            par_err        <= 1'b0;
            busy_o         <= 1'b0;
            rx_data_o      <= 8'd0;
            rx_valid_o     <= 1'b0;
            err_parity_o   <= 1'b0;
            err_overflow_o <= 1'b0;
            err_frame_o    <= 1'b0;
        end else begin
            err_parity_o   <= 1'b0;
            err_overflow_o <= 1'b0;
            err_frame_o    <= 1'b0;
            if (rx_valid_o && rx_ready_i)
                rx_valid_o <= 1'b0;
            if (!cfg_en_i) begin
                state      <= IDLE;
                busy_o     <= 1'b0;
                cnt        <= 16'd0;
                rx_valid_o <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        // the detection cycle counts as tick 0
                        if (fall) begin
                            state    <= START;
                            busy_o   <= 1'b1;
                            cnt      <= 16'd1;
                            div_q    <= cfg_div_i;
                            bits_q   <= cfg_bits_i;
                            par_q    <= cfg_parity_en_i;
                            stop2_q  <= cfg_stop_bits_i;
                            stop_idx <= 1'b0;
                            idx      <= 3'd0;
                            shreg    <= 8'd0;
                            par_err  <= 1'b0;
                        end
                    end
                    START: begin
                        if (cnt == (d_eff >> 1)) begin
                            cnt <= 16'd0;
                            if (!sync2) begin
                                state <= DATA;
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        if (hit) begin
                            cnt        <= 16'd0;
                            shreg[idx] <= sync2;
                            if (last_bit)
                                state <= par_q ? PARITY : STOP;
                            else
                                idx <= idx + 3'd1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    PARITY: begin
                        if (hit) begin
                            cnt     <= 16'd0;
                            par_err <= (^shreg) ^ sync2;
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    STOP: begin
                        if (hit) begin
                            cnt <= 16'd0;
                            if (!sync2) begin
                                err_frame_o <= 1'b1;
                                state       <= IDLE;
                                busy_o      <= 1'b0;
                            end else if (stop2_q && !stop_idx) begin
                                stop_idx <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                                if (!rx_valid_o || rx_ready_i) begin
                                    rx_data_o    <= shreg;
                                    rx_valid_o   <= 1'b1;
                                    err_parity_o <= par_err;
                                end else begin
                                    err_overflow_o <= 1'b1;
                                end
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        cnt    <= 16'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udma_uart_rx.sv
// Directed bench for udma_uart_rx: timing of sample/delivery,
// parity, overflow, framing, glitch rejection, abort and reset.
`timescale 1ns/1ps
module tb_udma_uart_rx;

    logic        clk;
    logic        rstn;
    logic        rx;
    logic        en;
    logic [15:0] div;
    logic        par;
    logic [1:0]  bits;
    logic        stop2;
    logic        ready;
    logic        busy_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        err_parity_o;
    logic        err_overflow_o;
    logic        err_frame_o;

    udma_uart_rx dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .rx_i           (rx),
        .cfg_en_i       (en),
        .cfg_div_i      (div),
        .cfg_parity_en_i(par),
        .cfg_bits_i     (bits),
        .cfg_stop_bits_i(stop2),
        .busy_o         (busy_o),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (ready),
        .err_parity_o   (err_parity_o),
        .err_overflow_o (err_overflow_o),
        .err_frame_o    (err_frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // event monitor, sampled mid-cycle
    int       busy_first, busy_last, nrise;
    bit       busy_seen, v_prev;
    int       vr_cyc [4];
    int       vr_dat [4];
    int       n_par, n_ovf, n_frm;
    int       par_cyc, ovf_cyc, frm_cyc;

    task automatic clear_mon();
        busy_first = 0;
        busy_last  = 0;
        busy_seen  = 0;
        nrise      = 0;
        v_prev     = rx_valid_o;
        for (int i = 0; i < 4; i++) begin
            vr_cyc[i] = 0;
            vr_dat[i] = 0;
        end
        n_par   = 0;
        n_ovf   = 0;
        n_frm   = 0;
        par_cyc = 0;
        ovf_cyc = 0;
        frm_cyc = 0;
    endtask

    always @(negedge clk) begin
        if (busy_o) begin
            if (!busy_seen) begin
                busy_first = cyc;
                busy_seen  = 1;
            end
            busy_last = cyc;
        end
        if (rx_valid_o && !v_prev && nrise < 4) begin
            vr_cyc[nrise] = cyc;
            vr_dat[nrise] = int'(rx_data_o);
            nrise++;
        end
        v_prev = rx_valid_o;
        if (err_parity_o) begin
            n_par++;
            par_cyc = cyc;
        end
        if (err_overflow_o) begin
            n_ovf++;
            ovf_cyc = cyc;
        end
        if (err_frame_o) begin
            n_frm++;
            frm_cyc = cyc;
        end
    end

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // called at posedge+1; t0 = cycle in which the start bit begins
    task automatic send(input int dv, input int nb, input logic [7:0] d,
                        input bit pe, input logic pb, input int ns,
                        input logic sv, input int trunc, output int t0);
        int bt;
        bt = ((dv < 3) ? 3 : dv) + 1;
        t0 = cyc;
        drive_bit(1'b0, bt);
        for (int k = 0; k < nb; k++)
            drive_bit(d[k], bt);
        if (pe)
            drive_bit(pb, bt);
        for (int s = 0; s < ns; s++)
            drive_bit(sv, (s == ns - 1) ? bt - trunc : bt);
    endtask

    int t0, t1, e, ta;

    initial begin
        rstn  = 1'b0;
        rx    = 1'b1;
        en    = 1'b1;
        div   = 16'd9;
        par   = 1'b0;
        bits  = 2'd3;
        stop2 = 1'b0;
        ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", rx_valid_o, 0);
        chk("rst_data", rx_data_o, 0);
        chk("rst_err", {err_parity_o, err_overflow_o, err_frame_o}, 0);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 8N1 div=9, 0xA5
        clear_mon();
        send(9, 8, 8'hA5, 0, 1'b0, 1, 1'b1, 0, t0);
        repeat (5) @(posedge clk);
        #1;
        e = t0 + 2;
        chk("a5_rise", vr_cyc[0], e + 95);
        chk("a5_data", vr_dat[0], 32'hA5);
        chk("a5_busy_first", busy_first, e + 1);
        chk("a5_busy_last", busy_last, e + 94);
        chk("a5_errs", n_par + n_ovf + n_frm, 0);

        // 7 bits even parity, wrong parity bit
        div  = 16'd15;
        bits = 2'd2;
        par  = 1'b1;
        clear_mon();
        send(15, 7, 8'h55, 1, 1'b1, 1, 1'b1, 0, t0);
        repeat (5) @(posedge clk);
        #1;
        e = t0 + 2;
        chk("par_nrise", nrise, 1);
        chk("par_rise", vr_cyc[0], e + 152);
        chk("par_data", vr_dat[0], 32'h55);
        chk("par_pulses", n_par, 1);
        chk("par_cycle", par_cyc, e + 152);

        // 5 bits, 2 stop, div=3, back to back
        div   = 16'd3;
        bits  = 2'd0;
        par   = 1'b0;
        stop2 = 1'b1;
        clear_mon();
        send(3, 5, 8'h13, 0, 1'b0, 2, 1'b1, 2, t0);
        send(3, 5, 8'h0C, 0, 1'b0, 2, 1'b1, 0, t1);
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_nrise", nrise, 2);
        chk("b2b_data0", vr_dat[0], 32'h13);
        chk("b2b_data1", vr_dat[1], 32'h0C);
        chk("b2b_rise0", vr_cyc[0], t0 + 32);
        chk("b2b_rise1", vr_cyc[1], t0 + 30 + 32);
        chk("b2b_errs", n_par + n_ovf + n_frm, 0);

        // overflow with ready low
        div   = 16'd9;
        bits  = 2'd3;
        stop2 = 1'b0;
        ready = 1'b0;
        clear_mon();
        send(9, 8, 8'h11, 0, 1'b0, 1, 1'b1, 0, t0);
        send(9, 8, 8'h22, 0, 1'b0, 1, 1'b1, 0, t1);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_nrise", nrise, 1);
        chk("ovf_data0", vr_dat[0], 32'h11);
        chk("ovf_pulses", n_ovf, 1);
        chk("ovf_cycle", ovf_cyc, t1 + 2 + 95);
        chk("ovf_hold", rx_data_o, 8'h11);
        ready = 1'b1;
        @(negedge clk);
        chk("ovf_valid_hi", rx_valid_o, 1);
        @(negedge clk);
        chk("ovf_valid_clr", rx_valid_o, 0);
        @(posedge clk);
        #1;

        // 10-cycle glitch, div=31
        div = 16'd31;
        clear_mon();
        rx = 1'b0;
        t0 = cyc;
        repeat (10) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("gl_busy_first", busy_first, t0 + 3);
        chk("gl_busy_last", busy_last, t0 + 2 + 15);
        chk("gl_nrise", nrise, 0);
        chk("gl_errs", n_par + n_ovf + n_frm, 0);

        // stop bit forced low
        clear_mon();
        send(31, 8, 8'hC3, 0, 1'b0, 1, 1'b0, 0, t0);
        rx = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("fr_pulses", n_frm, 1);
        chk("fr_cycle", frm_cyc, t0 + 2 + 15 + 288 + 1);
        chk("fr_nrise", nrise, 0);
        chk("fr_other", n_par + n_ovf, 0);

        // abort at data bit 3 with a byte pending
        div   = 16'd9;
        ready = 1'b0;
        send(9, 8, 8'h3C, 0, 1'b0, 1, 1'b1, 0, t0);
        repeat (5) @(posedge clk);
        #1;
        chk("ab_pending", rx_valid_o, 1);
        clear_mon();
        ta = cyc;
        fork
            send(9, 8, 8'h5A, 0, 1'b0, 1, 1'b1, 0, t1);
            begin
                while (cyc != ta + 46) begin
                    @(posedge clk);
                    #1;
                end
                en = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("ab_busy", busy_o, 0);
                chk("ab_valid", rx_valid_o, 0);
                chk("ab_data", rx_data_o, 8'h3C);
            end
        join
        en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("ab_quiet", nrise + n_par + n_ovf + n_frm, 0);

        // async reset mid-DATA
        send(9, 8, 8'h77, 0, 1'b0, 1, 1'b1, 0, t0);
        repeat (5) @(posedge clk);
        #1;
        chk("rs_pending", rx_valid_o, 1);
        ta = cyc;
        fork
            send(9, 8, 8'h5A, 0, 1'b0, 1, 1'b1, 0, t1);
            begin
                while (cyc != ta + 26) begin
                    @(posedge clk);
                    #1;
                end
                #2;
                rstn = 1'b0;
                #1;
                chk("rs_busy", busy_o, 0);
                chk("rs_valid", rx_valid_o, 0);
                chk("rs_data", rx_data_o, 0);
                chk("rs_err",
                    {err_parity_o, err_overflow_o, err_frame_o}, 0);
            end
        join
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rs_after", rx_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
